// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS front end.
//               Contents: fetch address width, instruction width,
//               the fetch FSM state type, the default reset PC and an
//               alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int PC_W     = 15;    // byte-address width of instruction memory
    localparam int INSN_W   = 32;    // instruction word width
    localparam int RESET_PC = 0;     // default boot address (word aligned)

    // Fetch controller states. Encoding is explicit so that waveform values
    // stay stable across tool versions.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lo_bits);
        return (lo_bits != 2'b00);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Bundle of every non-clock/reset signal of the fetch stage.
//               Ports (master = fetch stage side):
//                 imem_pc       out  fetch byte address
//                 imem_data     in   instruction word for imem_pc
//                 stall_i       in   hold PC and IF/ID
//                 flush_i       in   invalidate IF/ID
//                 redirect_i    in   taken branch/jump
//                 redirect_pc_i in   redirect target
//                 halt_i        in   stop fetching until reset
//                 ifid_insn     out  registered instruction
//                 ifid_pc4      out  registered PC+4
//                 ifid_valid    out  IF/ID holds a live instruction
//                 halted_o      out  fetch stage is halted
//                 fault_o       out  sticky misaligned-redirect flag
//                 fault_pc_o    out  offending redirect target
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int PC_W = mips_pkg::PC_W
);
    import mips_pkg::*;

    logic [PC_W-1:0]   imem_pc;
    logic [INSN_W-1:0] imem_data;
    logic              stall_i;
    logic              flush_i;
    logic              redirect_i;
    logic [PC_W-1:0]   redirect_pc_i;
    logic              halt_i;
    logic [INSN_W-1:0] ifid_insn;
    logic [PC_W-1:0]   ifid_pc4;
    logic              ifid_valid;
    logic              halted_o;
    logic              fault_o;
    logic [PC_W-1:0]   fault_pc_o;

    // Fetch stage side.
    modport master (
        output imem_pc,
        input  imem_data,
        input  stall_i,
        input  flush_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  halt_i,
        output ifid_insn,
        output ifid_pc4,
        output ifid_valid,
        output halted_o,
        output fault_o,
        output fault_pc_o
    );

    // Memory / hazard unit / decode side.
    modport slave (
        input  imem_pc,
        output imem_data,
        output stall_i,
        output flush_i,
        output redirect_i,
        output redirect_pc_i,
        output halt_i,
        input  ifid_insn,
        input  ifid_pc4,
        input  ifid_valid,
        input  halted_o,
        input  fault_o,
        input  fault_pc_o
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register with load / clear / hold control.
//               Ports:
//                 clk, rst_n     clock, synchronous active-low reset
//                 i_load         capture i_insn/i_pc4 and mark valid
//                 i_clear        drop the valid bit, payload holds
//                 i_insn, i_pc4  payload to capture
//                 o_insn, o_pc4  registered payload
//                 o_valid        registered valid bit
//               When neither control is active everything holds.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import mips_pkg::*;
#(
    parameter int PC_W = mips_pkg::PC_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_clear,
    input  wire logic [INSN_W-1:0] i_insn,
    input  wire logic [PC_W-1:0]   i_pc4,
    output logic      [INSN_W-1:0] o_insn,
    output logic      [PC_W-1:0]   o_pc4,
    output logic                   o_valid
);

    logic [INSN_W-1:0] r_insn;
    logic [PC_W-1:0]   r_pc4;
    logic              r_valid;

    // Clear only touches the valid bit; the stale payload is harmless and
    // keeping it avoids extra enables on the wide data flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_insn  <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_insn  <= i_insn;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_insn  = r_insn;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction fetch stage. Owns the program counter,
//               presents it to instruction memory, and captures the
//               returned word into the IF/ID register. Handles stall,
//               flush, redirect and halt; a misaligned redirect target is
//               recorded as a sticky fetch fault and halts the stage.
//               Ports:
//                 clk    single clock, rising edge
//                 rst_n  synchronous active-low reset
//                 bus    fetch_stage_if.master (memory, hazard, IF/ID,
//                        status signals)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              PC_W     = mips_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(mips_pkg::RESET_PC)
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fetch_stage_if.master  bus
);
    import mips_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic [PC_W-1:0]   w_pc_plus4;
    logic              r_fault;
    logic [PC_W-1:0]   r_fault_pc;
    logic              w_fault_set;
    logic              w_ifid_load;
    logic              w_ifid_clear;
    logic [INSN_W-1:0] w_ifid_insn;
    logic [PC_W-1:0]   w_ifid_pc4;
    logic              w_ifid_valid;

    // Truncation to PC_W gives the required wrap at the top of memory.
    assign w_pc_plus4 = r_pc + PC_W'(4);

    // ------------------------------------------------------------------
    // State / PC / fault registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= bus.redirect_pc_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, next-PC and IF/ID control, highest priority first
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_fault_set  = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_clear = 1'b0;

        case (r_state)
            ST_BOOT: begin
                // One idle cycle so memory sees a stable RESET_PC before
                // its first word is captured.
                w_state_next = ST_RUN;
            end

            ST_RUN: begin
                if (bus.halt_i) begin
                    // Halt beats a simultaneous redirect, so no fault is
                    // recorded in that case.
                    w_state_next = ST_HALT;
                    w_ifid_clear = 1'b1;
                end else if (bus.redirect_i &&
                             is_misaligned(bus.redirect_pc_i[1:0])) begin
                    w_fault_set  = 1'b1;
                    w_state_next = ST_HALT;
                    w_ifid_clear = 1'b1;
                end else if (bus.redirect_i) begin
                    // Redirect wins over stall: the word fetched this cycle
                    // is wrong-path and is squashed.
                    w_pc_next    = bus.redirect_pc_i;
                    w_ifid_clear = 1'b1;
                end else if (bus.stall_i) begin
                    w_ifid_clear = bus.flush_i;
                end else if (bus.flush_i) begin
                    w_pc_next    = w_pc_plus4;
                    w_ifid_clear = 1'b1;
                end else begin
                    w_pc_next    = w_pc_plus4;
                    w_ifid_load  = 1'b1;
                end
            end

            ST_HALT: begin
                // Only reset leaves HALT; IF/ID was already invalidated on
                // entry, so nothing changes here.
            end

            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------
    ifid_reg #(
        .PC_W (PC_W)
    ) u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ifid_load),
        .i_clear (w_ifid_clear),
        .i_insn  (bus.imem_data),
        .i_pc4   (w_pc_plus4),
        .o_insn  (w_ifid_insn),
        .o_pc4   (w_ifid_pc4),
        .o_valid (w_ifid_valid)
    );

    // ------------------------------------------------------------------
    // Outputs: all taken straight from registers
    // ------------------------------------------------------------------
    assign bus.imem_pc    = r_pc;
    assign bus.ifid_insn  = w_ifid_insn;
    assign bus.ifid_pc4   = w_ifid_pc4;
    assign bus.ifid_valid = w_ifid_valid;
    assign bus.halted_o   = (r_state == ST_HALT);
    assign bus.fault_o    = r_fault;
    assign bus.fault_pc_o = r_fault_pc;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage. The stimulus process
//               advances a behavioural model each cycle and queues the
//               outputs expected after the edge; a negedge monitor pops
//               and compares them. Directed scenarios are followed by a
//               randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int AW  = 15;
    localparam int MOD = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if #(.PC_W(AW)) bus ();

    fetch_stage #(
        .PC_W     (AW),
        .RESET_PC (15'd0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory, combinational read.
    logic [31:0] imem [0:MOD/4-1];
    assign bus.imem_data = imem[bus.imem_pc[AW-1:2]];

    typedef struct {
        int          pc;
        logic [31:0] insn;
        int          pc4;
        bit          valid;
        bit          halted;
        bit          fault;
        int          fpc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 = boot, 1 = run, 2 = halted.
    int          m_mode, m_pc, m_pc4, m_fpc;
    logic [31:0] m_insn;
    bit          m_valid, m_fault;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit f,
                              input bit rd, input int rpc, input bit h);
        if (!r) begin
            m_mode = 0; m_pc = 0; m_pc4 = 0; m_insn = '0;
            m_valid = 0; m_fault = 0; m_fpc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (h) begin
                m_mode = 2; m_valid = 0;
            end else if (rd && (rpc % 4) != 0) begin
                m_fault = 1; m_fpc = rpc; m_mode = 2; m_valid = 0;
            end else if (rd) begin
                m_pc = rpc; m_valid = 0;
            end else if (s) begin
                if (f) m_valid = 0;
            end else if (f) begin
                m_pc = (m_pc + 4) % MOD; m_valid = 0;
            end else begin
                m_insn  = imem[m_pc / 4];
                m_pc4   = (m_pc + 4) % MOD;
                m_pc    = m_pc4;
                m_valid = 1;
            end
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the edge.
    task automatic tick(input bit r, input bit s, input bit f,
                        input bit rd, input int rpc, input bit h);
        exp_t e;
        rst_n             = r;
        bus.stall_i       = s;
        bus.flush_i       = f;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc[AW-1:0];
        bus.halt_i        = h;
        model_step(r, s, f, rd, rpc, h);
        e.pc = m_pc; e.insn = m_insn; e.pc4 = m_pc4; e.valid = m_valid;
        e.halted = (m_mode == 2); e.fault = m_fault; e.fpc = m_fpc;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic junk();
        tick(1, $urandom_range(0, 1), $urandom_range(0, 1), 1,
             $urandom_range(0, MOD / 4 - 1) * 4, $urandom_range(0, 1));
    endtask

    // Monitor: one expectation per edge, compared away from the edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("mon_imem_pc",    bus.imem_pc,    e.pc);
            check("mon_ifid_valid", bus.ifid_valid, e.valid);
            check("mon_ifid_insn",  bus.ifid_insn,  e.insn);
            check("mon_ifid_pc4",   bus.ifid_pc4,   e.pc4);
            check("mon_halted",     bus.halted_o,   e.halted);
            check("mon_fault",      bus.fault_o,    e.fault);
            check("mon_fault_pc",   bus.fault_pc_o, e.fpc);
        end
    end

    initial begin
        int halt_cycles;
        for (int i = 0; i < MOD / 4; i++) imem[i] = $urandom;
        imem[0] = 32'h1111_1111;
        imem[1] = 32'h2222_2222;
        m_mode = 0; m_pc = 0; m_pc4 = 0; m_insn = '0;
        m_valid = 0; m_fault = 0; m_fpc = 0;

        // Reset state.
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        check("rst_imem_pc", bus.imem_pc, 0);
        check("rst_valid", bus.ifid_valid, 0);
        check("rst_fault", bus.fault_o, 0);

        // Boot then free run: first valid word two cycles after release.
        run(1);
        check("boot_valid", bus.ifid_valid, 0);
        check("boot_pc_hold", bus.imem_pc, 0);
        run(1);
        check("first_valid", bus.ifid_valid, 1);
        check("first_insn", bus.ifid_insn, 32'h1111_1111);
        check("first_pc4", bus.ifid_pc4, 4);
        run(1);
        check("second_insn", bus.ifid_insn, 32'h2222_2222);
        check("second_pc4", bus.ifid_pc4, 8);

        // Stall for 3 cycles, then resume with the next word.
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, 0, 0);
            check("stall_pc", bus.imem_pc, 8);
            check("stall_pc4", bus.ifid_pc4, 8);
        end
        run(1);
        check("resume_insn", bus.ifid_insn, imem[2]);
        check("resume_pc4", bus.ifid_pc4, 12);

        // Redirect under stall.
        tick(1, 1, 0, 1, 32'h0100, 0);
        check("redir_pc", bus.imem_pc, 32'h0100);
        check("redir_bubble", bus.ifid_valid, 0);
        run(1);
        check("redir_insn", bus.ifid_insn, imem[32'h40]);
        check("redir_pc4", bus.ifid_pc4, 32'h0104);

        // Wrap at the top of the address space.
        tick(1, 0, 0, 1, 32760, 0);
        run(1);
        check("wrap_pc4_a", bus.ifid_pc4, 32764);
        run(1);
        check("wrap_pc4_b", bus.ifid_pc4, 0);
        run(1);
        check("wrap_pc4_c", bus.ifid_pc4, 4);

        // Flush with stall, then halt.
        tick(1, 1, 1, 0, 0, 0);
        check("fs_valid", bus.ifid_valid, 0);
        check("fs_pc_hold", bus.imem_pc, 4);
        tick(1, 0, 0, 0, 0, 1);
        check("halt_flag", bus.halted_o, 1);
        for (int i = 0; i < 3; i++) junk();
        check("halt_pc_frozen", bus.imem_pc, 4);

        // Misaligned redirect: sticky fault, cleared only by reset.
        tick(0, 0, 0, 0, 0, 0);
        run(4);
        tick(1, 0, 0, 1, 32'h0102, 0);
        check("fault_flag", bus.fault_o, 1);
        check("fault_pc", bus.fault_pc_o, 32'h0102);
        check("fault_halted", bus.halted_o, 1);
        for (int i = 0; i < 3; i++) junk();
        check("fault_pc_sticky", bus.fault_pc_o, 32'h0102);
        tick(0, 0, 0, 0, 0, 0);
        check("fault_cleared", bus.fault_o, 0);
        check("halt_cleared", bus.halted_o, 0);

        // Halt with a misaligned redirect: halt wins, no fault.
        run(3);
        tick(1, 0, 0, 1, 32'h0206, 1);
        check("halt_vs_redir", bus.fault_o, 0);
        check("halt_vs_redir_h", bus.halted_o, 1);

        // Randomized run.
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, s, f, rd, h;
            int rpc;
            r  = ($urandom_range(0, 199) != 0) && (halt_cycles < 12);
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 9) == 0);
            h  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0)
                rpc = $urandom_range(0, MOD / 4 - 1) * 4 + $urandom_range(1, 3);
            else if ($urandom_range(0, 3) == 0)
                rpc = MOD - 4 * $urandom_range(1, 3);
            else
                rpc = $urandom_range(0, MOD / 4 - 1) * 4;
            tick(r, s, f, rd, rpc, h);
            halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d entries, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
